tile_cmd_gen: RTL and testbench
===============================

# tile_cmd_gen

Downstream stage of the map scanner. Each time the scanner raises `diff` for a changed grid cell, this block captures the cell coordinates and object code. It then drives one complete rectangle-fill transaction on an 8-bit 8080-style TFT bus (ILI9341 command set): column window, page window, then a solid-colour pixel burst. It returns a single-cycle `cmd_done` pulse, which the scanner uses to resume its sweep.

## Interface
- `TILE_W`, 20, tile width in pixels.
- `TILE_H`, 20, tile height in pixels.
- `GRID_H`, 12, number of valid grid rows (y = 0..GRID_H-1).

Ports:
- `clk` input 1: system clock.
- `nrst` input 1: reset. Asynchronous, active-low.
- `diff` input 1: cell-update request from the scanner. Level; sampled only in IDLE.
- `x` input 4: grid column, 0..15.
- `y` input 4: grid row, 0..15. Only 0..GRID_H-1 is drawable.
- `obj_code` input 3: object at the cell.
- `cmd_done` output 1: one-cycle pulse when the transaction is complete.
- `busy` output 1: high whenever the state is not IDLE.
- `lcd_data` output 8: bus data byte.
- `lcd_dcx` output 1: 0 = command byte, 1 = data byte.
- `lcd_wrn` output 1: write strobe, active-low. The panel latches on its rising edge.
- `lcd_csx` output 1: chip select, active-low.

## Operation
- States: IDLE, CASET_C, CASET_A, PASET_C, PASET_A, RAMWR_C, PIXEL, DONE.
- IDLE with `diff`=1:
  - Register `x`, `y` and `obj_code`.
  - If y < GRID_H, go to CASET_C; otherwise go straight to DONE with no bus activity.
- Colour LUT (RGB565), based on the registered `obj_code`:
  - 0 → 0x0000 (empty)
  - 1 → 0x07E0 (body)
  - 2 → 0xFFE0 (head)
  - 3 → 0xF800 (apple)
  - 4 → 0x001F (border)
  - 5..7 → 0xFFFF
- Window arithmetic uses a 9-bit intermediate, sent as a 16-bit big-endian value:
  - xs = x·TILE_W, xe = xs+TILE_W−1
  - ys = y·TILE_H, ye = ys+TILE_H−1
- Byte stream, in order:
  - 0x2A (dcx=0), then xs_hi, xs_lo, xe_hi, xe_lo (dcx=1).
  - 0x2B (dcx=0), then ys_hi, ys_lo, ye_hi, ye_lo (dcx=1).
  - 0x2C (dcx=0), then TILE_W·TILE_H pixels, each sent colour_hi then colour_lo (dcx=1).
- Counters:
  - 2-bit argument counter for CASET_A and PASET_A (0..3).
  - 10-bit pixel-byte counter for PIXEL (0..2·TILE_W·TILE_H−1).
- DONE: `cmd_done`=1 for exactly one cycle, then IDLE.
- `diff` is ignored in every state except IDLE. A `diff` held high through DONE starts a new transaction on the first IDLE cycle.
- Inputs are registered at capture, so changes on `x`, `y` or `obj_code` during a transaction have no effect.

## Timing
- Reset values: `cmd_done`=0, `busy`=0, `lcd_wrn`=1, `lcd_csx`=1, `lcd_dcx`=1, `lcd_data`=0x00, state IDLE, all counters 0.
- Each byte takes 2 cycles:
  - Phase 0: `lcd_data` and `lcd_dcx` valid, `lcd_wrn`=0.
  - Phase 1: same data, `lcd_wrn`=1.
  - Data is stable across the rising edge of `lcd_wrn`.
- Capture edge is E0.
  - `busy`=1 from E0.
  - Byte k occupies the cycles after edges E0+2k+1 and E0+2k+2.
  - Total bytes = 11 + 2·TILE_W·TILE_H = 811 with defaults, i.e. 1622 cycles.
  - `cmd_done` is high in the cycle after edge E0+1623.
  - `busy` falls one cycle later.
- `lcd_csx` goes low together with byte 0 phase 0 and returns high on the cycle after the final byte's phase 1, i.e. in DONE.
- Out-of-range row: `cmd_done` is high in the cycle after edge E0+1. `lcd_wrn` and `lcd_csx` stay high throughout.
- Reset mid-transaction: all outputs take their reset values immediately. No `cmd_done` is issued, and the next request replays the full sequence.

## Test plan
- **Reset:** assert `nrst`=0 mid-PIXEL → `lcd_wrn`=1, `lcd_csx`=1, `busy`=0 and `cmd_done`=0 asynchronously. After release, a new `diff` gives a full 811-byte transaction.
- **Tile (0,0), obj_code=4:**
  - Bytes 2A,00,00,00,13, 2B,00,00,00,13, 2C, then 400×(00,1F).
  - `lcd_dcx`=0 only on bytes 0, 5 and 10.
  - One `cmd_done` pulse 1623 cycles after capture.
- **Tile (15,11), obj_code=3:**
  - CASET args 01,2C,01,3F.
  - PASET args 00,DC,00,EF.
  - Pixels F8,00 ×400.
  - Exactly 800 `lcd_wrn` rising edges after 0x2C.
- **Request while busy:** pulse `diff` with x=5 at cycle 100 of an active transaction → ignored. The window bytes remain those of the original request, and exactly one `cmd_done` is produced.
- **Out-of-range row y=12, obj_code=1:**
  - `cmd_done` 1 cycle after capture.
  - `lcd_wrn` never low; `lcd_csx` never low.
- **Back-to-back:** `diff` held high with cells (4,4,code 2) then (7,4,code 3) switched after the first `cmd_done` → two complete transactions. The second starts on the first IDLE cycle with CASET args 00,8C,00,9F and pixels F8,00.

Source files
------------

// File: rtl/tile_cmd_gen.sv
// Rectangle-fill command generator: turns one changed grid cell into a CASET/PASET/RAMWR
// transaction on an 8-bit 8080-style TFT bus, then pulses cmd_done.
module tile_cmd_gen #(
    parameter int unsigned TILE_W = 20,
    parameter int unsigned TILE_H = 20,
    parameter int unsigned GRID_H = 12
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       diff,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic [2:0] obj_code,
    output logic       cmd_done,
    output logic       busy,
    output logic [7:0] lcd_data,
    output logic       lcd_dcx,
    output logic       lcd_wrn,
    output logic       lcd_csx
);

    typedef enum logic [2:0] {
        IDLE, CASET_C, CASET_A, PASET_C, PASET_A, RAMWR_C, PIXEL, DONE
    } state_e;

    localparam logic [9:0] PIX_LAST = 10'(2 * TILE_W * TILE_H - 1);
    localparam logic [8:0] W9       = 9'(TILE_W);
    localparam logic [8:0] H9       = 9'(TILE_H);
    localparam logic [4:0] GRID_H5  = 5'(GRID_H);

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [1:0]  arg_q, arg_d;
    logic [9:0]  pix_q, pix_d;
    logic [3:0]  x_q, y_q;
    logic [2:0]  obj_q;

    logic        cmd_done_q, busy_q, dcx_q, wrn_q, csx_q;
    logic [7:0]  data_q;

    logic        cap;
    logic        drive;
    logic [7:0]  byte_d;
    logic        byte_dcx;
    logic [8:0]  xs, xe, ys, ye, win_s, win_e;
    logic [15:0] colour;
    logic [7:0]  arg_byte;

    always_comb begin
        xs = 9'(x_q) * W9;
        xe = xs + W9 - 9'd1;
        ys = 9'(y_q) * H9;
        ye = ys + H9 - 9'd1;
        win_s = (state_q == PASET_A) ? ys : xs;
        win_e = (state_q == PASET_A) ? ye : xe;

        case (obj_q)
            3'd0:    colour = 16'h0000;
            3'd1:    colour = 16'h07E0;
            3'd2:    colour = 16'hFFE0;
            3'd3:    colour = 16'hF800;
            3'd4:    colour = 16'h001F;
            default: colour = 16'hFFFF;
        endcase

        // Window arguments go out big-endian: start hi/lo, then end hi/lo.
        case (arg_q)
            2'd0:    arg_byte = {7'd0, win_s[8]};
            2'd1:    arg_byte = win_s[7:0];
            2'd2:    arg_byte = {7'd0, win_e[8]};
            default: arg_byte = win_e[7:0];
        endcase
    end

    always_comb begin
        state_d  = state_q;
        arg_d    = arg_q;
        pix_d    = pix_q;
        cap      = 1'b0;
        drive    = 1'b0;
        byte_d   = '0;
        byte_dcx = 1'b1;

        case (state_q)
            IDLE: begin
                if (diff) begin
                    cap     = 1'b1;
                    arg_d   = '0;
                    pix_d   = '0;
                    state_d = ({1'b0, y} < GRID_H5) ? CASET_C : DONE;
                end
            end
            CASET_C: begin
                drive    = 1'b1;
                byte_d   = 8'h2A;
                byte_dcx = 1'b0;
                if (phase_q) state_d = CASET_A;
            end
            CASET_A, PASET_A: begin
                drive  = 1'b1;
                byte_d = arg_byte;
                if (phase_q) begin
                    arg_d = arg_q + 2'd1;
                    if (arg_q == 2'd3) state_d = (state_q == CASET_A) ? PASET_C : RAMWR_C;
                end
            end
            PASET_C: begin
                drive    = 1'b1;
                byte_d   = 8'h2B;
                byte_dcx = 1'b0;
                if (phase_q) state_d = PASET_A;
            end
            RAMWR_C: begin
                drive    = 1'b1;
                byte_d   = 8'h2C;
                byte_dcx = 1'b0;
                if (phase_q) state_d = PIXEL;
            end
            PIXEL: begin
                drive  = 1'b1;
                byte_d = pix_q[0] ? colour[7:0] : colour[15:8];
                if (phase_q) begin
                    if (pix_q == PIX_LAST) state_d = DONE;
                    else                   pix_d   = pix_q + 10'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                arg_d   = '0;
                pix_d   = '0;
            end
            default: state_d = IDLE;
        endcase

        phase_d = drive ? ~phase_q : 1'b0;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= IDLE;
            phase_q <= 1'b0;
            arg_q   <= '0;
            pix_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            obj_q   <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            arg_q   <= arg_d;
            pix_q   <= pix_d;
            if (cap) begin
                x_q   <= x;
                y_q   <= y;
                obj_q <= obj_code;
            end
        end
    end

    // Bus pins are registered copies of the current byte/phase, so they lag the state by one cycle.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cmd_done_q <= 1'b0;
            busy_q     <= 1'b0;
            data_q     <= '0;
            dcx_q      <= 1'b1;
            wrn_q      <= 1'b1;
            csx_q      <= 1'b1;
        end else begin
            cmd_done_q <= (state_q == DONE);
            busy_q     <= (state_q != IDLE) || cap;
            data_q     <= drive ? byte_d : '0;
            dcx_q      <= drive ? byte_dcx : 1'b1;
            wrn_q      <= drive ? phase_q : 1'b1;
            csx_q      <= ~drive;
        end
    end

    assign cmd_done = cmd_done_q;
    assign busy     = busy_q;
    assign lcd_data = data_q;
    assign lcd_dcx  = dcx_q;
    assign lcd_wrn  = wrn_q;
    assign lcd_csx  = csx_q;

endmodule

// File: tb/tb_tile_cmd_gen.sv
// Scoreboard bench for tile_cmd_gen: stimulus queues expected bus bytes, cmd_done cycles
// and busy windows; a negedge monitor compares the DUT against them.
module tb_tile_cmd_gen;

    localparam int unsigned TW = 20;
    localparam int unsigned TH = 20;
    localparam int unsigned GH = 12;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       diff_s = 1'b0;
    logic [3:0] x_s = '0;
    logic [3:0] y_s = '0;
    logic [2:0] obj_s = '0;
    logic       cmd_done, busy, lcd_dcx, lcd_wrn, lcd_csx;
    logic [7:0] lcd_data;

    tile_cmd_gen #(.TILE_W(TW), .TILE_H(TH), .GRID_H(GH)) dut (
        .clk      (clk),
        .nrst     (nrst),
        .diff     (diff_s),
        .x        (x_s),
        .y        (y_s),
        .obj_code (obj_s),
        .cmd_done (cmd_done),
        .busy     (busy),
        .lcd_data (lcd_data),
        .lcd_dcx  (lcd_dcx),
        .lcd_wrn  (lcd_wrn),
        .lcd_csx  (lcd_csx)
    );

    always #5 clk = ~clk;

    typedef struct { logic [7:0] d; logic dcx; int unsigned cyc; } bexp_t;
    typedef struct { int unsigned f; int unsigned u; } win_t;

    bexp_t       bq[$];
    int unsigned dq[$];
    win_t        wq[$];

    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;
    logic        prev_wrn = 1'b1;
    logic [8:0]  prev_bus = '0;
    int unsigned lut[8] = '{32'h0000, 32'h07E0, 32'hFFE0, 32'hF800,
                            32'h001F, 32'hFFFF, 32'hFFFF, 32'hFFFF};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: window bytes from plain arithmetic; byte k completes (wrn high) at E0+2k+2.
    task automatic issue(input int unsigned xx, input int unsigned yy, input int unsigned code,
                         input bit hold, output int unsigned done_at);
        int unsigned e0, xs, xe, ys, ye, col;
        logic [8:0]  seq[$];
        x_s    = 4'(xx);
        y_s    = 4'(yy);
        obj_s  = 3'(code);
        diff_s = 1'b1;
        e0     = cyc + 1;
        if (yy < GH) begin
            xs  = xx * TW;  xe = xs + TW - 1;
            ys  = yy * TH;  ye = ys + TH - 1;
            col = lut[code];
            seq.push_back({1'b0, 8'h2A});
            seq.push_back({1'b1, 8'(xs >> 8)}); seq.push_back({1'b1, 8'(xs)});
            seq.push_back({1'b1, 8'(xe >> 8)}); seq.push_back({1'b1, 8'(xe)});
            seq.push_back({1'b0, 8'h2B});
            seq.push_back({1'b1, 8'(ys >> 8)}); seq.push_back({1'b1, 8'(ys)});
            seq.push_back({1'b1, 8'(ye >> 8)}); seq.push_back({1'b1, 8'(ye)});
            seq.push_back({1'b0, 8'h2C});
            for (int i = 0; i < int'(TW * TH); i++) begin
                seq.push_back({1'b1, 8'(col >> 8)});
                seq.push_back({1'b1, 8'(col)});
            end
            foreach (seq[k]) bq.push_back('{seq[k][7:0], seq[k][8], e0 + 2 * 32'(k) + 2});
            done_at = e0 + 2 * 32'(seq.size()) + 1;
        end else begin
            done_at = e0 + 1;
        end
        dq.push_back(done_at);
        wq.push_back('{e0, done_at});
        if (!hold) begin
            @(negedge clk);
            diff_s = 1'b0;
        end
    endtask

    task automatic wait_until(input int unsigned t);
        while (cyc < t) @(negedge clk);
    endtask

    always @(negedge clk) begin
        logic        exp_busy, exp_done, idle_exp;
        bexp_t       b;
        if (!nrst) begin
            prev_wrn = 1'b1;
        end else begin
            while (wq.size() > 0 && wq[0].u < cyc) void'(wq.pop_front());
            exp_busy = 1'b0;
            foreach (wq[i]) if (wq[i].f <= cyc && cyc <= wq[i].u) exp_busy = 1'b1;
            chk("busy", 32'(busy), 32'(exp_busy));

            exp_done = (dq.size() > 0) && (dq[0] == cyc);
            chk("cmd_done", 32'(cmd_done), 32'(exp_done));
            if (exp_done) begin
                void'(dq.pop_front());
                chk("bytes_left_at_done", 32'(bq.size() == 0 || bq[0].cyc > cyc), 32'd1);
            end

            idle_exp = (bq.size() == 0) || (bq[0].cyc > cyc + 1);
            chk("csx", 32'(lcd_csx), 32'(idle_exp));
            chk("wrn", 32'(lcd_wrn), idle_exp ? 32'd1 : 32'(cyc == bq[0].cyc));

            if (!prev_wrn && lcd_wrn) begin
                chk("byte_expected", 32'(bq.size() != 0), 32'd1);
                if (bq.size() != 0) begin
                    b = bq.pop_front();
                    chk("byte_cycle", cyc, b.cyc);
                    chk("byte_ph1", 32'({lcd_dcx, lcd_data}), 32'({b.dcx, b.d}));
                    chk("byte_ph0", 32'(prev_bus), 32'({b.dcx, b.d}));
                end
            end
            prev_wrn = lcd_wrn;
            prev_bus = {lcd_dcx, lcd_data};
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned d, d2, e0;
        repeat (3) @(negedge clk);
        chk("rst_cmd_done", 32'(cmd_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_wrn", 32'(lcd_wrn), 32'd1);
        chk("rst_csx", 32'(lcd_csx), 32'd1);
        chk("rst_dcx", 32'(lcd_dcx), 32'd1);
        chk("rst_data", 32'(lcd_data), 32'd0);
        @(posedge clk); #2 nrst = 1'b1;
        @(negedge clk);

        issue(0, 0, 4, 1'b0, d);
        wait_until(d + 1);
        issue(15, 11, 3, 1'b0, d);
        wait_until(d + 1);

        issue(2, 3, 1, 1'b0, d);
        e0 = d - (2 * (11 + 2 * TW * TH) + 1);
        wait_until(e0 + 100);
        x_s = 4'd5; diff_s = 1'b1;
        @(negedge clk);
        diff_s = 1'b0;
        wait_until(d + 1);

        issue(3, 12, 1, 1'b0, d);
        wait_until(d + 1);

        issue(4, 4, 2, 1'b1, d);
        wait_until(d);
        issue(7, 4, 3, 1'b0, d2);
        wait_until(d2 + 1);

        repeat (5) begin
            issue($urandom_range(15), $urandom_range(15), $urandom_range(7), 1'b0, d);
            x_s = 4'($urandom); y_s = 4'($urandom); obj_s = 3'($urandom);
            wait_until(d + 1);
        end

        issue(9, 6, 5, 1'b0, d);
        e0 = d - (2 * (11 + 2 * TW * TH) + 1);
        wait_until(e0 + 900);
        @(posedge clk); #2 nrst = 1'b0;
        #1;
        chk("arst_wrn", 32'(lcd_wrn), 32'd1);
        chk("arst_csx", 32'(lcd_csx), 32'd1);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_cmd_done", 32'(cmd_done), 32'd0);
        bq.delete();
        dq.delete();
        wq.delete();
        repeat (3) @(negedge clk);
        @(posedge clk); #2 nrst = 1'b1;
        @(negedge clk);
        issue(9, 6, 5, 1'b0, d);
        wait_until(d + 1);

        repeat (5) @(negedge clk);
        chk("bytes_outstanding", 32'(bq.size()), 32'd0);
        chk("dones_outstanding", 32'(dq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
